// File: rtl/nand_prog_seq_if.sv
// Toggle-stage and NAND bus signals between the program sequencer and the
// toggle/pin stage. The sequencer is the master; the toggle stage is the slave.
interface nand_prog_seq_if;
    logic        tog_enable;
    logic [11:0] tog_cnt;
    logic [4:0]  tog_vec1;   // {CE_n, CLE, ALE, WE_n, RE_n} while WE_n is low
    logic [4:0]  tog_vec2;   // {CE_n, CLE, ALE, WE_n, RE_n} while WE_n is high / idle
    logic        tog_done;
    logic [11:0] tog_idx;
    logic [7:0]  io_out;
    logic        io_oe;
    logic        rb_n;

    modport master (
        output tog_enable, tog_cnt, tog_vec1, tog_vec2, io_out, io_oe,
        input  tog_done, tog_idx, rb_n
    );

    modport slave (
        input  tog_enable, tog_cnt, tog_vec1, tog_vec2, io_out, io_oe,
        output tog_done, tog_idx, rb_n
    );
endinterface

// File: rtl/nand_prog_seq.sv
// NAND page-program sequencer: issues 80h, five address cycles, the data
// burst from the page buffer and 10h through the toggle stage, then waits
// for ready/busy to return high (or times out).
//
// state  | meaning
// IDLE   | waiting for start, bus released
// CMD1   | toggling the 80h program-setup command
// GAP1   | two idle cycles after CMD1
// ADDR   | toggling 2 column + 3 row address bytes
// GAP2   | two idle cycles after ADDR
// DATA   | toggling byte_count bytes from the page buffer
// GAP3   | two idle cycles after DATA
// CMD2   | toggling the 10h program-confirm command
// RBWAIT | tWB blanking, then waiting for rb_n high or timeout
// FIN    | one-cycle done pulse, chip deselected
module nand_prog_seq #(
    parameter logic [19:0] TIMEOUT = 20'd200000,
    parameter logic [3:0]  TWB     = 4'd8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [15:0]     col_addr,
    input  logic [23:0]     row_addr,
    input  logic [11:0]     byte_count,
    output logic [11:0]     buf_addr,
    input  logic [7:0]      buf_data,
    nand_prog_seq_if.master nand_bus,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CMD1   = 4'd1;
    localparam logic [3:0] S_GAP1   = 4'd2;
    localparam logic [3:0] S_ADDR   = 4'd3;
    localparam logic [3:0] S_GAP2   = 4'd4;
    localparam logic [3:0] S_DATA   = 4'd5;
    localparam logic [3:0] S_GAP3   = 4'd6;
    localparam logic [3:0] S_CMD2   = 4'd7;
    localparam logic [3:0] S_RBWAIT = 4'd8;
    localparam logic [3:0] S_FIN    = 4'd9;

    localparam logic [4:0]  VEC_IDLE = 5'b10011;
    localparam logic [4:0]  VEC_SEL  = 5'b00011;
    localparam logic [19:0] TWB_EXT  = {16'd0, TWB};
    localparam logic [19:0] TO_LAST  = TIMEOUT - 20'd1;

    logic [3:0]  state;
    logic [3:0]  phase_next;
    logic [15:0] col_q;
    logic [23:0] row_q;
    logic [11:0] cnt_q;
    logic        gap_cnt;
    logic [19:0] rb_cnt;
    logic [7:0]  addr_byte;

    // Status and page-buffer address follow the state directly so that reset
    // takes them back to idle values immediately.
    assign busy            = (state != S_IDLE);
    assign nand_bus.io_oe  = (state >= S_CMD1) && (state <= S_CMD2);
    assign buf_addr        = (state == S_DATA) ? nand_bus.tog_idx : 12'd0;

    // Address byte selected by the toggle stage's pulse index.
    always_comb begin
        case (nand_bus.tog_idx)
            12'd0:   addr_byte = col_q[7:0];
            12'd1:   addr_byte = col_q[15:8];
            12'd2:   addr_byte = row_q[7:0];
            12'd3:   addr_byte = row_q[15:8];
            default: addr_byte = row_q[23:16];
        endcase
    end

    // State that follows each toggle phase once its pulses are done.
    always_comb begin
        case (state)
            S_CMD1:  phase_next = S_GAP1;
            S_ADDR:  phase_next = S_GAP2;
            S_DATA:  phase_next = S_GAP3;
            default: phase_next = S_RBWAIT;
        endcase
    end

    // Sequencer state, toggle-stage setup and registered bus data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            nand_bus.tog_enable <= 1'b0;
            nand_bus.tog_cnt    <= 12'd0;
            nand_bus.tog_vec1   <= VEC_IDLE;
            nand_bus.tog_vec2   <= VEC_IDLE;
            nand_bus.io_out     <= 8'h00;
            done                <= 1'b0;
            error               <= 1'b0;
            col_q               <= 16'd0;
            row_q               <= 24'd0;
            cnt_q               <= 12'd0;
            gap_cnt             <= 1'b0;
            rb_cnt              <= 20'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (byte_count == 12'd0) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            col_q               <= col_addr;
                            row_q               <= row_addr;
                            cnt_q               <= byte_count;
                            error               <= 1'b0;
                            nand_bus.tog_enable <= 1'b0;
                            nand_bus.tog_cnt    <= 12'd1;
                            nand_bus.tog_vec1   <= 5'b01001;
                            nand_bus.tog_vec2   <= 5'b01011;
                            nand_bus.io_out     <= 8'h80;
                            state               <= S_CMD1;
                        end
                    end
                end
                S_CMD1, S_ADDR, S_DATA, S_CMD2: begin
                    if (state == S_ADDR) begin
                        nand_bus.io_out <= addr_byte;
                    end else if (state == S_DATA) begin
                        nand_bus.io_out <= buf_data;
                    end
                    // Enable is held off for the first cycle so the toggle
                    // stage sees settled vectors and count.
                    if (!nand_bus.tog_enable) begin
                        nand_bus.tog_enable <= 1'b1;
                    end else if (nand_bus.tog_done) begin
                        nand_bus.tog_enable <= 1'b0;
                        nand_bus.tog_vec2   <= VEC_SEL;
                        gap_cnt             <= 1'b1;
                        rb_cnt              <= 20'd0;
                        state               <= phase_next;
                    end
                end
                S_GAP1, S_GAP2, S_GAP3: begin
                    if (gap_cnt) begin
                        gap_cnt <= 1'b0;
                    end else if (state == S_GAP1) begin
                        nand_bus.tog_cnt  <= 12'd5;
                        nand_bus.tog_vec1 <= 5'b00101;
                        nand_bus.tog_vec2 <= 5'b00111;
                        nand_bus.io_out   <= col_q[7:0];
                        state             <= S_ADDR;
                    end else if (state == S_GAP2) begin
                        nand_bus.tog_cnt  <= cnt_q;
                        nand_bus.tog_vec1 <= 5'b00001;
                        nand_bus.tog_vec2 <= 5'b00011;
                        nand_bus.io_out   <= buf_data;
                        state             <= S_DATA;
                    end else begin
                        nand_bus.tog_cnt  <= 12'd1;
                        nand_bus.tog_vec1 <= 5'b01001;
                        nand_bus.tog_vec2 <= 5'b01011;
                        nand_bus.io_out   <= 8'h10;
                        state             <= S_CMD2;
                    end
                end
                S_RBWAIT: begin
                    // rb_n is not trusted until tWB has elapsed after 10h.
                    if ((rb_cnt >= TWB_EXT) && nand_bus.rb_n) begin
                        done              <= 1'b1;
                        nand_bus.tog_vec1 <= VEC_IDLE;
                        nand_bus.tog_vec2 <= VEC_IDLE;
                        state             <= S_FIN;
                    end else if (rb_cnt == TO_LAST) begin
                        error             <= 1'b1;
                        done              <= 1'b1;
                        nand_bus.tog_vec1 <= VEC_IDLE;
                        nand_bus.tog_vec2 <= VEC_IDLE;
                        state             <= S_FIN;
                    end else begin
                        rb_cnt <= rb_cnt + 20'd1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_prog_seq.sv
// Directed bench for nand_prog_seq with a behavioural toggle stage and page buffer.
module tb_nand_prog_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] col_addr = 16'd0;
    logic [23:0] row_addr = 24'd0;
    logic [11:0] byte_count = 12'd0;
    logic [11:0] buf_addr;
    logic [7:0]  buf_data;
    logic        busy, done, error;

    nand_prog_seq_if nif();

    nand_prog_seq #(.TIMEOUT(20'd1000)) dut (
        .clk(clk), .reset(reset), .start(start), .col_addr(col_addr),
        .row_addr(row_addr), .byte_count(byte_count), .buf_addr(buf_addr),
        .buf_data(buf_data), .nand_bus(nif), .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    int m_cyc, m_pulse;
    logic [7:0] bus_log [$];
    logic [7:0] buf_mem [4];

    always #5 clk = ~clk;

    // Page buffer: synchronous read, one cycle of latency.
    always @(posedge clk) buf_data <= (buf_addr < 12'd4) ? buf_mem[buf_addr[1:0]] : 8'hee;

    // Toggle stage: 3 cycles per pulse, bus byte captured at the WE_n rise.
    initial begin
        nif.tog_done = 1'b0;
        nif.tog_idx = 12'd0;
        m_cyc = 0;
        m_pulse = 0;
        forever begin
            @(negedge clk);
            if (reset || nif.tog_enable !== 1'b1) begin
                nif.tog_done = 1'b0;
                nif.tog_idx = 12'd0;
                m_cyc = 0;
                m_pulse = 0;
            end else if (!nif.tog_done) begin
                m_cyc++;
                if (m_cyc == 3) begin
                    bus_log.push_back(nif.io_out);
                    m_cyc = 0;
                    m_pulse++;
                    if (m_pulse == int'(nif.tog_cnt)) nif.tog_done = 1'b1;
                    else nif.tog_idx = 12'(m_pulse);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (nif.tog_enable === 1'b1) en_cnt++;
        end
    end

    task automatic pulse_start(input logic [15:0] c, input logic [23:0] r, input logic [11:0] n);
        @(negedge clk);
        start = 1'b1;
        col_addr = c;
        row_addr = r;
        byte_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the first negedge on which RBWAIT is visible (vec2 00011 after 10h).
    task automatic wait_rbwait(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 3000 && !(nif.tog_vec2 === 5'b01011 && nif.io_out === 8'h10)) begin
            @(negedge clk);
            n++;
        end
        if (n < 3000) begin
            n = 0;
            while (n < 100 && nif.tog_vec2 !== 5'b00011) begin
                @(negedge clk);
                n++;
            end
            ok = (n < 100);
        end
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, nif.tog_enable, nif.io_oe} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, error, nif.tog_enable, nif.io_oe});
        end
        checks++;
        if ({nif.tog_vec1, nif.tog_vec2} !== 10'b10011_10011) begin
            errors++;
            $display("FAIL reset_vectors: got %b expected 1001110011", {nif.tog_vec1, nif.tog_vec2});
        end
        checks++;
        if (nif.tog_cnt !== 12'd0 || nif.io_out !== 8'h00 || buf_addr !== 12'd0) begin
            errors++;
            $display("FAIL reset_data: got cnt=%h io=%h addr=%h expected 0", nif.tog_cnt, nif.io_out, buf_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_program();
        logic [7:0] exp_b [11];
        logic [7:0] got;
        int cyc;
        bit ok;
        exp_b = '{8'h80, 8'h23, 8'h01, 8'h78, 8'h56, 8'h04, 8'hd0, 8'hd1, 8'hd2, 8'hd3, 8'h10};
        bus_log.delete();
        done_cnt = 0;
        nif.rb_n = 1'b0;
        pulse_start(16'h0123, 24'h045678, 12'd4);
        checks++;
        if (busy !== 1'b1 || nif.io_oe !== 1'b1) begin
            errors++;
            $display("FAIL prog_busy_oe: got %b%b expected 11", busy, nif.io_oe);
        end
        wait_rbwait(ok);
        checks++;
        if (!ok || nif.io_oe !== 1'b0) begin
            errors++;
            $display("FAIL prog_rbwait: got ok=%0d oe=%b expected ok=1 oe=0", ok, nif.io_oe);
        end
        repeat (100) @(negedge clk);
        nif.rb_n = 1'b1;
        wait_done(200, cyc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prog_done_seen: got none within %0d cycles expected done", cyc);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus_log.size() != 11) begin
            errors++;
            $display("FAIL prog_byte_count: got %0d expected 11", bus_log.size());
        end
        for (int i = 0; i < 11; i++) begin
            got = (i < bus_log.size()) ? bus_log[i] : 8'hxx;
            checks++;
            if (got !== exp_b[i]) begin
                errors++;
                $display("FAIL prog_byte%0d: got %h expected %h", i, got, exp_b[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prog_end: got done_cnt=%0d error=%b busy=%b expected 1 0 0", done_cnt, error, busy);
        end
    endtask

    task automatic test_zero_count();
        int en_before;
        done_cnt = 0;
        en_before = en_cnt;
        pulse_start(16'h1111, 24'h222222, 12'd0);
        checks++;
        if ({done, error, busy} !== 3'b110) begin
            errors++;
            $display("FAIL zero_pulse: got done/error/busy=%b expected 110", {done, error, busy});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL zero_after: got done=%b error=%b expected 0 1", done, error);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (en_cnt != en_before || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_no_toggle: got en_cycles=%0d done_cnt=%0d expected 0 1", en_cnt - en_before, done_cnt);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        nif.rb_n = 1'b0;
        pulse_start(16'h0000, 24'h000001, 12'd1);
        wait_rbwait(ok);
        wait_done(1500, cyc, ok);
        checks++;
        if (!ok || cyc != 1000) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d (ok=%0d) expected 1000", cyc, ok);
        end
        checks++;
        if (error !== 1'b1 || nif.tog_vec2 !== 5'b10011) begin
            errors++;
            $display("FAIL timeout_state: got error=%b vec2=%b expected 1 10011", error, nif.tog_vec2);
        end
        nif.rb_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n = 0;
        bit ok;
        bus_log.delete();
        done_cnt = 0;
        nif.rb_n = 1'b1;
        pulse_start(16'h0123, 24'h045678, 12'd4);
        while (n < 500 && nif.tog_vec1 !== 5'b00101) begin
            @(negedge clk);
            n++;
        end
        pulse_start(16'hffff, 24'hffffff, 12'd3);
        wait_done(3000, cyc, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || done_cnt != 1 || bus_log.size() != 11) begin
            errors++;
            $display("FAIL b2b_single: got ok=%0d done_cnt=%0d bytes=%0d expected 1 1 11", ok, done_cnt, bus_log.size());
        end
        checks++;
        if (bus_log.size() == 11 && (bus_log[1] !== 8'h23 || bus_log[5] !== 8'h04 || bus_log[9] !== 8'hd3)) begin
            errors++;
            $display("FAIL b2b_bytes: got %h %h %h expected 23 04 d3", bus_log[1], bus_log[5], bus_log[9]);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_error_clear: got %b expected 0", error);
        end
    endtask

    task automatic test_twb();
        int cyc;
        bit ok;
        nif.rb_n = 1'b1;
        pulse_start(16'h0042, 24'h000100, 12'd2);
        wait_rbwait(ok);
        wait_done(50, cyc, ok);
        checks++;
        if (!ok || cyc != 9) begin
            errors++;
            $display("FAIL twb_blank: got done after %0d cycles (ok=%0d) expected 9", cyc, ok);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int en_before, done_before;
        pulse_start(16'h0123, 24'h045678, 12'd4);
        while (n < 3000 && !(nif.tog_vec1 === 5'b00001 && nif.tog_idx === 12'd2)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL rstmid_reach: got no DATA idx2 within %0d cycles expected reached", n);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, error, nif.tog_enable, nif.io_oe} !== 5'b0 || buf_addr !== 12'd0) begin
            errors++;
            $display("FAIL rstmid_flags: got %b addr=%h expected 00000 000", {busy, done, error, nif.tog_enable, nif.io_oe}, buf_addr);
        end
        checks++;
        if ({nif.tog_vec1, nif.tog_vec2} !== 10'b10011_10011 || nif.tog_cnt !== 12'd0 || nif.io_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_bus: got v=%b cnt=%h io=%h expected 1001110011 000 00", {nif.tog_vec1, nif.tog_vec2}, nif.tog_cnt, nif.io_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        en_before = en_cnt;
        done_before = done_cnt;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || en_cnt != en_before || done_cnt != done_before) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b en=%0d done=%0d expected 0 0 0", busy, en_cnt - en_before, done_cnt - done_before);
        end
    endtask

    initial begin
        nif.rb_n = 1'b1;
        buf_mem[0] = 8'hd0;
        buf_mem[1] = 8'hd1;
        buf_mem[2] = 8'hd2;
        buf_mem[3] = 8'hd3;
        test_reset();
        test_program();
        test_zero_count();
        test_timeout();
        test_back_to_back();
        test_twb();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_prog_seq.md
NAND_PROG_SEQ -- requirements
Module: nand_prog_seq

Interface
REQ-001 SHALL use parameter TIMEOUT, default 20'd200000, max clk cycles to wait for rb_n high after program confirm.
REQ-002 SHALL use parameter TWB, default 4'd8, clk cycles rb_n is ignored after confirm command.
REQ-003 SHALL have ports: clk in 1 system clock (200 MHz); reset in 1 async active-high reset.
REQ-004 SHALL have ports: start in 1 program request pulse; col_addr in 16 column address; row_addr in 24 row address; byte_count in 12 data bytes to write (1..4095).
REQ-005 SHALL have ports: buf_addr out 12 page-buffer read address; buf_data in 8 page-buffer read data, valid 1 cycle after buf_addr.
REQ-006 SHALL have ports: tog_enable out 1; tog_cnt out 12; tog_vec1 out 5 (WE_n-low vector); tog_vec2 out 5 (WE_n-high/idle vector); tog_done in 1; tog_idx in 12 (pulse count from toggle stage).
REQ-007 SHALL have ports: io_out out 8 NAND bus byte; io_oe out 1 bus drive enable; rb_n in 1 NAND ready/busy (pre-synchronised).
REQ-008 SHALL have ports: busy out 1; done out 1 one-cycle completion pulse; error out 1 sticky failure flag.
REQ-009 Vector bit order SHALL be {CE_n, CLE, ALE, WE_n, RE_n}.

Function
REQ-010 States: IDLE, CMD1, GAP1, ADDR, GAP2, DATA, GAP3, CMD2, RBWAIT, FIN.
REQ-011 IDLE: tog_vec2=5'b10011, io_oe=0, busy=0; start while IDLE moves to CMD1 and latches col_addr, row_addr, byte_count; start outside IDLE ignored.
REQ-012 start with byte_count==0 SHALL set error=1, pulse done, stay IDLE, issue no toggle.
REQ-013 Each toggle phase: vectors and tog_cnt set on entry; tog_enable asserted from 2nd cycle of phase; held until tog_done sampled 1; deasserted next cycle.
REQ-014 After tog_done, each GAP state SHALL hold tog_enable=0 for exactly 2 cycles with tog_vec2=5'b00011, then advance.
REQ-015 CMD1: tog_cnt=1, vec1=5'b01001, vec2=5'b01011, io_out=8'h80.
REQ-016 ADDR: tog_cnt=5, vec1=5'b00101, vec2=5'b00111; io_out by tog_idx 0..4 = col[7:0], col[15:8], row[7:0], row[15:8], row[23:16].
REQ-017 DATA: tog_cnt=byte_count, vec1=5'b00001, vec2=5'b00011; buf_addr=tog_idx; io_out=buf_data for index tog_idx.
REQ-018 io_out SHALL be registered, valid within 2 cycles of each tog_idx change, stable until 1 cycle after the next change (hold >= 1 cycle past WE_n rise).
REQ-019 CMD2: tog_cnt=1, vec1=5'b01001, vec2=5'b01011, io_out=8'h10.
REQ-020 io_oe=1 in CMD1 through CMD2 inclusive; 0 otherwise.
REQ-021 RBWAIT: tog_vec2=5'b00011; ignore rb_n for TWB cycles; then rb_n==1 moves to FIN; 20-bit counter from CMD2 exit; count reaching TIMEOUT sets error=1, moves to FIN.
REQ-022 FIN: done=1 one cycle, tog_vec2=5'b10011, next state IDLE.
REQ-023 busy=1 in every state except IDLE.
REQ-024 error SHALL clear on accepted start with valid byte_count; otherwise holds.
REQ-025 Simultaneous tog_done and timeout impossible (disjoint states); rb_n ignored outside RBWAIT.

Reset
REQ-026 On reset: state IDLE, tog_enable=0, tog_cnt=0, tog_vec1=5'b10011, tog_vec2=5'b10011, io_out=0, io_oe=0, buf_addr=0, busy=0, done=0, error=0, counters 0.
REQ-027 Reset mid-operation SHALL abort immediately to reset values; no phase resumes after release.

Verification
REQ-028 start, col=16'h0123, row=24'h045678, byte_count=4, toggle model, rb_n low 100 cycles -> bus bytes 80,23,01,78,56,04,d0..d3,10; one done pulse; error=0.
REQ-029 start with byte_count=0 -> done pulse next cycle, error=1, tog_enable never asserted.
REQ-030 rb_n held low after CMD2 with TIMEOUT=1000 -> done at cycle ~1000 of RBWAIT, error=1, vec2 back to 10011.
REQ-031 reset asserted during DATA at tog_idx=2 -> all outputs reset values next edge; IDLE after release.
REQ-032 second start pulse during ADDR -> ignored; single command sequence, single done.
REQ-033 rb_n high immediately after CMD2 -> FIN not entered before TWB cycles elapse.
